// File: rtl/mmio_pkg.sv
// Shared register offsets, response record and byte-lane merge for the
// peripheral-window responder.
package mmio_pkg;

  localparam logic [7:0] OFF_LED      = 8'h00;
  localparam logic [7:0] OFF_SEG      = 8'h04;
  localparam logic [7:0] OFF_SW       = 8'h08;
  localparam logic [7:0] OFF_BTN      = 8'h0C;
  localparam logic [7:0] OFF_CYC_LO   = 8'h10;
  localparam logic [7:0] OFF_CYC_HI   = 8'h14;
  localparam logic [7:0] OFF_CMP_LO   = 8'h18;
  localparam logic [7:0] OFF_CMP_CTRL = 8'h1C;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  function automatic logic [31:0] wstrb_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mmio_responder_input_sync_edge.sv
// Multi-flop synchronizer for asynchronous board inputs, plus a rising-edge
// pulse taken from the last synchronized stage.
module input_sync_edge #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  if (STAGES < 2 || STAGES > 3) begin : g_bad_stages
    $error("input_sync_edge: STAGES must be 2 or 3");
  end

  logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]             prev_q, prev_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = din;
    for (int i = 1; i < STAGES; i++) sync_d[i] = sync_q[i-1];
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/mmio_responder.sv
// Data-bus responder for the peripheral window: LED/seven-segment outputs,
// switch and button inputs, a 64-bit cycle counter and a timer compare.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_F000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  input  logic [15:0] switch,
  input  logic [4:0]  button,
  output logic [15:0] led,
  output logic [31:0] seg_data,
  output logic        irq
);

  logic [15:0] sw_level, sw_rise_unused;
  logic [4:0]  btn_level_unused, btn_rise;

  input_sync_edge #(.WIDTH(16), .STAGES(SYNC_STAGES)) u_sw_sync (
    .clk(clk), .rst(rst), .din(switch), .level(sw_level), .rise(sw_rise_unused)
  );

  input_sync_edge #(.WIDTH(5), .STAGES(SYNC_STAGES)) u_btn_sync (
    .clk(clk), .rst(rst), .din(button), .level(btn_level_unused), .rise(btn_rise)
  );

  logic [15:0] led_q, led_d;
  logic [31:0] seg_q, seg_d;
  logic [4:0]  btn_cap_q, btn_cap_d;
  logic [63:0] cyc_q, cyc_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] cmp_q, cmp_d;
  logic        en_q, en_d;
  logic        pend_q, pend_d;
  logic        rsp_valid_q, rsp_valid_d;
  rsp_t        rsp_q, rsp_d;

  logic [7:0]  off;
  logic        mapped, addr_err, accept, wr_en, rd_en;
  logic [31:0] rd_data, merge_val;
  logic [4:0]  btn_clr;
  logic        pend_clr;

  assign req_ready = !rsp_valid_q || rsp_ready;

  always_comb begin
    off    = req_addr[7:0];
    accept = req_valid && req_ready;

    mapped  = 1'b1;
    rd_data = '0;
    case (off)
      OFF_LED:      rd_data = {16'h0, led_q};
      OFF_SEG:      rd_data = seg_q;
      OFF_SW:       rd_data = {16'h0, sw_level};
      OFF_BTN:      rd_data = {27'h0, btn_cap_q};
      OFF_CYC_LO:   rd_data = cyc_q[31:0];
      OFF_CYC_HI:   rd_data = shadow_q;
      OFF_CMP_LO:   rd_data = cmp_q;
      OFF_CMP_CTRL: rd_data = {30'h0, pend_q, en_q};
      default:      mapped  = 1'b0;
    endcase

    addr_err = (req_addr[31:8] != BASE_ADDR[31:8]) || (req_addr[1:0] != 2'b00) || !mapped;
    wr_en    = accept && req_we && !addr_err;
    rd_en    = accept && !req_we && !addr_err;
    // Merging against the read view keeps unwritten lanes of each register intact.
    merge_val = wstrb_merge(rd_data, req_wdata, req_wstrb);

    led_d    = led_q;
    seg_d    = seg_q;
    cmp_d    = cmp_q;
    en_d     = en_q;
    shadow_d = shadow_q;
    cyc_d    = cyc_q + 64'd1;
    btn_clr  = '0;
    pend_clr = 1'b0;

    if (wr_en) begin
      case (off)
        OFF_LED:    led_d = merge_val[15:0];
        OFF_SEG:    seg_d = merge_val;
        OFF_CMP_LO: cmp_d = merge_val;
        OFF_BTN:    if (req_wstrb[0]) btn_clr = req_wdata[4:0];
        OFF_CMP_CTRL: begin
          if (req_wstrb[0]) begin
            en_d     = req_wdata[0];
            pend_clr = req_wdata[1];
          end
        end
        default: ;
      endcase
    end

    if (rd_en && off == OFF_CYC_LO) shadow_d = cyc_q[63:32];

    // Set terms are OR'd in after the clear so a coincident event wins.
    btn_cap_d = (btn_cap_q & ~btn_clr) | btn_rise;
    pend_d    = (pend_q & ~pend_clr) | (en_q && (cyc_q[31:0] == cmp_q));

    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_d.err   = addr_err;
      rsp_d.rdata = rd_en ? rd_data : 32'h0;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q       <= '0;
      seg_q       <= '0;
      btn_cap_q   <= '0;
      cyc_q       <= '0;
      shadow_q    <= '0;
      cmp_q       <= '0;
      en_q        <= 1'b0;
      pend_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      led_q       <= led_d;
      seg_q       <= seg_d;
      btn_cap_q   <= btn_cap_d;
      cyc_q       <= cyc_d;
      shadow_q    <= shadow_d;
      cmp_q       <= cmp_d;
      en_q        <= en_d;
      pend_q      <= pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_q.rdata;
  assign rsp_err   = rsp_q.err;
  assign led       = led_q;
  assign seg_data  = seg_q;
  assign irq       = pend_q && en_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Scoreboard bench for mmio_responder: requests push expected responses,
// a negedge monitor pops and compares them as the DUT delivers.
module tb_mmio_responder;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [3:0]  req_wstrb;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [15:0] switch, led;
  logic [4:0]  button;
  logic [31:0] seg_data;
  logic        irq;

  always #5 clk = ~clk;

  mmio_responder #(.BASE_ADDR(32'hFFFF_F000), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_wstrb(req_wstrb), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .switch(switch), .button(button), .led(led),
    .seg_data(seg_data), .irq(irq)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   ncyc  = 0;
  logic rr_rand = 1'b0;
  logic new_rsp = 1'b1;

  // Reference state of the register file, kept as plain values.
  logic [63:0] m_cyc = '0;
  logic [63:0] m_adj = '0;
  logic [15:0] m_led = '0, m_sw = '0;
  logic [31:0] m_seg = '0, m_cmp = '0, m_shadow = '0;
  logic [4:0]  m_btn = '0;
  logic        m_en = 1'b0, m_pend = 1'b0;

  always @(posedge clk) begin
    ncyc  <= ncyc + 1;
    m_cyc <= rst ? 64'd0 : m_cyc + 64'd1;
  end

  always @(posedge clk) begin
    #1;
    if (rr_rand) rsp_ready = 1'($urandom_range(0, 1));
  end

  function automatic logic [63:0] cur_cyc();
    return m_cyc + m_adj;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_access(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                              input logic [31:0] wd, output logic [31:0] rd, output logic err);
    logic [7:0]  off;
    logic [63:0] c;
    off = addr[7:0];
    err = (addr[31:8] != 24'hFFFFF0) || (addr[1:0] != 2'b00) || (off > 8'h1C);
    rd  = 32'h0;
    c   = cur_cyc();
    if (err) return;
    if (!we) begin
      case (off)
        8'h00: rd = {16'h0, m_led};
        8'h04: rd = m_seg;
        8'h08: rd = {16'h0, m_sw};
        8'h0C: rd = {27'h0, m_btn};
        8'h10: begin rd = c[31:0]; m_shadow = c[63:32]; end
        8'h14: rd = m_shadow;
        8'h18: rd = m_cmp;
        8'h1C: rd = {30'h0, m_pend, m_en};
        default: ;
      endcase
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) begin
          case (off)
            8'h00: if (b < 2) m_led[8*b +: 8] = wd[8*b +: 8];
            8'h04: m_seg[8*b +: 8] = wd[8*b +: 8];
            8'h18: m_cmp[8*b +: 8] = wd[8*b +: 8];
            8'h0C: if (b == 0) m_btn = m_btn & ~wd[4:0];
            8'h1C: if (b == 0) begin m_en = wd[0]; if (wd[1]) m_pend = 1'b0; end
            default: ;
          endcase
        end
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after acceptance.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] wd, output int waited);
    exp_t        e;
    logic [31:0] rd;
    logic        er;
    int          w;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wstrb = strb; req_wdata = wd;
    w = 0;
    @(negedge clk);
    while (!req_ready) begin
      w++;
      if (w > 200) begin
        $display("FAIL req_accept: req_ready=%0b, expected 1 within 200 cycles", req_ready);
        $fatal(1, "request never accepted");
      end
      @(negedge clk);
    end
    model_access(we, addr, strb, wd, rd, er);
    e.rdata = rd; e.err = er; e.acc = ncyc;
    sb_q.push_back(e);
    waited = w;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic req(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                     input logic [31:0] wd);
    int w;
    issue(we, addr, strb, wd, w);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      new_rsp = 1'b1;
    end else if (rsp_valid) begin
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", {63'h0, rsp_valid}, 64'h0);
      end else begin
        if (new_rsp) chk("latency", 64'(ncyc), 64'(sb_q[0].acc + 1));
        chk("rdata", {32'h0, rsp_rdata}, {32'h0, sb_q[0].rdata});
        chk("err", {63'h0, rsp_err}, {63'h0, sb_q[0].err});
        if (rsp_ready) begin
          void'(sb_q.pop_front());
          new_rsp = 1'b1;
        end else begin
          new_rsp = 1'b0;
        end
      end
    end else begin
      new_rsp = 1'b1;
      if (sb_q.size() != 0 && sb_q[0].acc < ncyc) chk("rsp_valid_late", {63'h0, rsp_valid}, 64'h1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time %0t, expected completion earlier", $time);
    $fatal(1, "watchdog");
  end

  logic [7:0]  offs [8] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C};

  initial begin
    int          w, b, sel;
    logic        we;
    logic [31:0] addr;
    logic [23:0] bad_base;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_wstrb = '0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1; switch = '0; button = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {63'h0, req_ready}, 64'h1);
    chk("rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    chk("rst_rsp_rdata", {32'h0, rsp_rdata}, 64'h0);
    chk("rst_rsp_err",   {63'h0, rsp_err}, 64'h0);
    chk("rst_led",       {48'h0, led}, 64'h0);
    chk("rst_seg",       {32'h0, seg_data}, 64'h0);
    chk("rst_irq",       {63'h0, irq}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // LED byte-lane store then read back
    req(1'b1, 32'hFFFF_F000, 4'b0001, 32'h0000_A5A5);
    chk("led_store", {48'h0, led}, 64'h00A5);
    req(1'b0, 32'hFFFF_F000, 4'b0000, 32'h0);

    // Timer compare at counter value 100
    req(1'b1, 32'hFFFF_F018, 4'b1111, 32'd100);
    req(1'b1, 32'hFFFF_F01C, 4'b0001, 32'h1);
    b = 0;
    @(negedge clk);
    while (cur_cyc() != 64'd100 && b < 400) begin @(negedge clk); b++; end
    chk("irq_at_match", {63'h0, irq}, 64'h0);
    @(negedge clk);
    chk("irq_after_match", {63'h0, irq}, 64'h1);
    m_pend = 1'b1;
    @(posedge clk); #1;
    req(1'b0, 32'hFFFF_F01C, 4'b0000, 32'h0);
    req(1'b1, 32'hFFFF_F01C, 4'b0001, 32'h3);
    @(negedge clk);
    chk("irq_cleared", {63'h0, irq}, 64'h0);
    @(posedge clk); #1;
    req(1'b0, 32'hFFFF_F01C, 4'b0000, 32'h0);
    req(1'b1, 32'hFFFF_F01C, 4'b0001, 32'h0);

    // Backpressure on a SWITCH load
    switch = 16'h1234; m_sw = 16'h1234;
    tick(SYNC + 3);
    rsp_ready = 1'b0;
    req(1'b0, 32'hFFFF_F008, 4'b0000, 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("hold_req_ready", {63'h0, req_ready}, 64'h0);
      chk("hold_rdata", {32'h0, rsp_rdata}, 64'h1234);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    issue(1'b0, 32'hFFFF_F000, 4'b0000, 32'h0, w);
    chk("accept_on_release", 64'(w), 64'h0);

    // Button capture, set-wins against a clear, then a clean clear
    button = 5'b00100;
    tick(10);
    button = 5'b00000;
    tick(5);
    m_btn = 5'h04;
    req(1'b0, 32'hFFFF_F00C, 4'b0000, 32'h0);
    button = 5'b00100;
    tick(SYNC);
    req(1'b1, 32'hFFFF_F00C, 4'b0001, 32'h4);
    m_btn = 5'h04;
    tick(4);
    button = 5'b00000;
    tick(5);
    req(1'b0, 32'hFFFF_F00C, 4'b0000, 32'h0);
    req(1'b1, 32'hFFFF_F00C, 4'b0001, 32'h4);
    req(1'b0, 32'hFFFF_F00C, 4'b0000, 32'h0);

    // Error cases
    req(1'b0, 32'hFFFF_F020, 4'b0000, 32'h0);
    req(1'b0, 32'hFFFF_F002, 4'b0000, 32'h0);
    req(1'b1, 32'hFFFF_E000, 4'b1111, 32'hFFFF_FFFF);
    chk("led_unchanged", {48'h0, led}, {48'h0, m_led});

    // Randomized traffic with random response backpressure
    m_sw = 16'($urandom); switch = m_sw;
    tick(SYNC + 4);
    rr_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 11);
      we  = 1'($urandom_range(0, 1));
      if (sel < 8) begin
        addr = {24'hFFFFF0, offs[sel]};
        if (sel == 7) we = 1'b0;
      end else if (sel < 10) begin
        addr = {24'hFFFFF0, 6'($urandom_range(8, 63)), 2'b00};
      end else if (sel == 10) begin
        addr = {24'hFFFFF0, offs[$urandom_range(0, 7)][7:2], 2'($urandom_range(1, 3))};
      end else begin
        bad_base = 24'hFFFFF0 ^ 24'($urandom_range(1, 16777215));
        addr = {bad_base, offs[$urandom_range(0, 7)]};
      end
      req(we, addr, 4'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) tick(1);
    end
    chk("led_after_random", {48'h0, led}, {48'h0, m_led});
    chk("seg_after_random", {32'h0, seg_data}, {32'h0, m_seg});
    rr_rand = 1'b0;
    @(posedge clk); #2;
    rsp_ready = 1'b1;
    tick(3);

    // Atomic 64-bit read across the low-word wrap
    force dut.cyc_q = 64'h0000_0000_FFFF_FFFF;
    m_adj = 64'h0000_0000_FFFF_FFFF - m_cyc;
    req(1'b0, 32'hFFFF_F010, 4'b0000, 32'h0);
    release dut.cyc_q;
    req(1'b0, 32'hFFFF_F014, 4'b0000, 32'h0);

    b = 0;
    while (sb_q.size() != 0 && b < 50) begin @(posedge clk); b++; end
    #1;
    chk("scoreboard_drained", 64'(sb_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
